tr_track_ctrl: RTL and testbench

//  Tracking-mode stepper controller. Samples a 12-bit ADC value x on data_valid, compares it

---
 rtl/tr_pkg.sv | 16 +
 rtl/tr_track_ctrl_if.sv | 30 +++
 rtl/tr_step_gen.sv | 59 +++++
 rtl/tr_track_ctrl.sv | 147 ++++++++++++++
 tb/tb_tr_track_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/tr_pkg.sv
// Shared types and default parameters for the tracking-mode stepper controller.
package tr_pkg;

  // Controller operating state: parked, slow stepping, fast stepping.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } tr_state_e;

  localparam int TR_W        = 12;
  localparam int TR_DIV_FAST = 1000;
  localparam int TR_DIV_SLOW = 4000;
  localparam int TR_PULSE_W  = 1;

endpackage

// File: rtl/tr_track_ctrl_if.sv
// ADC-side inputs and stepper-driver outputs of the tracking controller.
interface tr_track_ctrl_if
  import tr_pkg::*;
#(
  parameter int W = TR_W
) ();

  logic [W-1:0] x;
  logic [W-1:0] x0;
  logic [W-1:0] dx1;
  logic [W-1:0] dx2;
  logic         data_valid;
  logic         tr_mode_enable;
  logic         drv_SM;
  logic         drv_step;
  logic         drv_dir;

  // Source of samples/settings; sink of the driver pins.
  modport master (
    output x, x0, dx1, dx2, data_valid, tr_mode_enable,
    input  drv_SM, drv_step, drv_dir
  );

  // The controller itself.
  modport slave (
    input  x, x0, dx1, dx2, data_valid, tr_mode_enable,
    output drv_SM, drv_step, drv_dir
  );

endinterface

// File: rtl/tr_step_gen.sv
// Step-period counter and pulse shaper.
// tick0 marks count 0 of each period; the registered step pulse is high for
// PULSE_W clocks starting one clock after the count leaves 0, so anything
// latched on tick0 is stable a full clock before the step rising edge.
module tr_step_gen #(
  parameter int CW      = 12,
  parameter int PULSE_W = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          restart,
  input  logic [CW-1:0] div,
  output logic          step,
  output logic          tick0
);

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] PW  = CW'(PULSE_W);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          step_q;
  logic          step_d;
  logic          active_s;

  assign active_s = run & ~restart;
  assign tick0    = active_s & (cnt_q == {CW{1'b0}});
  assign step     = step_q;

  // Advance the period counter and shape the step pulse; hold both at zero when stopped or restarting.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (!active_s) begin
      cnt_d  = {CW{1'b0}};
      step_d = 1'b0;
    end else begin
      if (cnt_q >= (div - ONE)) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + ONE;
      end
      step_d = (cnt_q >= ONE) && (cnt_q <= PW);
    end
  end

  // Counter and pulse registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= {CW{1'b0}};
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/tr_track_ctrl.sv
// Tracking-mode stepper controller: samples the ADC value, classifies the
// error against the setpoint into IDLE/SLOW/FAST and drives the stepper
// enable, direction and step pins at the matching step rate.
module tr_track_ctrl
  import tr_pkg::*;
#(
  parameter int W        = TR_W,
  parameter int DIV_FAST = TR_DIV_FAST,
  parameter int DIV_SLOW = TR_DIV_SLOW,
  parameter int PULSE_W  = TR_PULSE_W
) (
  input  logic             clk,
  input  logic             rst,
  tr_track_ctrl_if.slave   bus
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX + 1);

  // Dead band wins ties (mag == dx1 parks); mag == dx2 stays slow.
  // When dx2 < dx1 everything outside the dead band is fast.
  function automatic tr_state_e classify(input logic [W-1:0] mag,
                                         input logic [W-1:0] dx1,
                                         input logic [W-1:0] dx2);
    tr_state_e cls;
    if (mag <= dx1) begin
      cls = ST_IDLE;
    end else if (mag > dx2) begin
      cls = ST_FAST;
    end else begin
      cls = ST_SLOW;
    end
    return cls;
  endfunction

  logic [W-1:0]  x_q;
  logic [W-1:0]  x_d;
  logic          pend_q;
  logic          pend_d;
  tr_state_e     state_q;
  tr_state_e     state_d;
  logic          drv_sm_q;
  logic          drv_sm_d;
  logic          drv_dir_q;
  logic          drv_dir_d;

  logic [W:0]    err_s;
  logic [W-1:0]  mag_s;
  logic          err_pos_s;
  tr_state_e     cls_s;
  logic          run_s;
  logic          restart_s;
  logic [CW-1:0] div_s;
  logic          step_s;
  logic          tick0_s;

  // Signed error as a W+1-bit two's complement value; its magnitude always fits W bits.
  assign err_s     = {1'b0, x_q} - {1'b0, bus.x0};
  assign mag_s     = err_s[W] ? (~err_s[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : err_s[W-1:0];
  assign err_pos_s = ~err_s[W] & (err_s != {(W+1){1'b0}});
  assign cls_s     = classify(mag_s, bus.dx1, bus.dx2);

  // Capture x on every strobe; only strobes seen while enabled request a reclassification.
  always_comb begin
    x_d    = x_q;
    pend_d = 1'b0;
    if (bus.data_valid) begin
      x_d    = bus.x;
      pend_d = bus.tr_mode_enable;
    end else begin
      x_d    = x_q;
      pend_d = 1'b0;
    end
  end

  // Next state: forced IDLE when tracking is not permitted, else follow a fresh classification.
  always_comb begin
    state_d = state_q;
    if (!bus.tr_mode_enable) begin
      state_d = ST_IDLE;
    end else if (pend_q) begin
      state_d = cls_s;
    end else begin
      state_d = state_q;
    end
  end

  assign run_s     = (state_d != ST_IDLE);
  assign restart_s = (state_d != state_q);

  // Step period for the current state; the counter restarts on any state change anyway.
  always_comb begin
    div_s = CW'(DIV_SLOW);
    case (state_q)
      ST_FAST: div_s = CW'(DIV_FAST);
      ST_SLOW: div_s = CW'(DIV_SLOW);
      ST_IDLE: div_s = CW'(DIV_SLOW);
      default: div_s = CW'(DIV_SLOW);
    endcase
  end

  // Driver enable follows the next state; direction is only re-latched at count 0 of a period.
  always_comb begin
    drv_sm_d  = run_s;
    drv_dir_d = drv_dir_q;
    if (tick0_s) begin
      drv_dir_d = err_pos_s;
    end else begin
      drv_dir_d = drv_dir_q;
    end
  end

  // Sample, FSM and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= {W{1'b0}};
      pend_q    <= 1'b0;
      state_q   <= ST_IDLE;
      drv_sm_q  <= 1'b0;
      drv_dir_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      drv_sm_q  <= drv_sm_d;
      drv_dir_q <= drv_dir_d;
    end
  end

  tr_step_gen #(
    .CW      (CW),
    .PULSE_W (PULSE_W)
  ) u_step_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .restart (restart_s),
    .div     (div_s),
    .step    (step_s),
    .tick0   (tick0_s)
  );

  assign bus.drv_SM   = drv_sm_q;
  assign bus.drv_step = step_s;
  assign bus.drv_dir  = drv_dir_q;

endmodule

// File: tb/tb_tr_track_ctrl.sv
// Directed, scoreboard-driven bench for tr_track_ctrl (default 1000/4000 step dividers).
module tb_tr_track_ctrl;

  localparam int W      = 12;
  localparam int P_FAST = 1000;
  localparam int P_SLOW = 4000;

  typedef struct {
    string tag;
    logic  sm;
    logic  dir;
    int    period;   // 0 = parked, no steps expected
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  tr_track_ctrl_if #(.W(W)) bus ();

  tr_track_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Wait for a rising edge of drv_step seen at negedges; n = negedges waited, -1 on timeout.
  task automatic wait_rise(input int limit, output int n);
    logic prev;
    logic done;
    prev = bus.drv_step;
    done = 1'b0;
    n    = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!done) begin
        @(negedge clk);
        if (bus.drv_step === 1'b1 && prev === 1'b0) begin
          n    = i;
          done = 1'b1;
        end
        prev = bus.drv_step;
      end
    end
  endtask

  // One-cycle data_valid strobe; returns at the negedge after the capturing posedge.
  task automatic do_sample(input int xv);
    @(negedge clk);
    bus.x          = W'(xv);
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  // Push the expectation, strobe the sample, then check entry, latency, direction and period.
  task automatic run_case(input string tag, input int xv, input logic sm, input logic dir, input int period);
    exp_t e;
    int   n;
    sb.push_back('{tag, sm, dir, period});
    do_sample(xv);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_sm"}, {31'd0, bus.drv_SM}, {31'd0, e.sm});
    if (e.period == 0) begin
      wait_rise(60, n);
      chk({e.tag, "_nostep"}, n, -32'sd1);
    end else begin
      wait_rise(10, n);
      chk({e.tag, "_first"}, n, 32'd2);
      chk({e.tag, "_dir"}, {31'd0, bus.drv_dir}, {31'd0, e.dir});
      @(negedge clk);
      chk({e.tag, "_width"}, {31'd0, bus.drv_step}, 32'd0);
      wait_rise(e.period + 10, n);
      chk({e.tag, "_period"}, n, e.period - 1);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int n_dir;
    int n_rise;
    logic prev_dir;
    logic prev_step;
    n_tests = 0;
    n_fail  = 0;

    // 1: reset with busy inputs keeps every output low
    rst                = 1'b0;
    bus.x              = W'(25);
    bus.x0             = W'(5);
    bus.dx1            = W'(5);
    bus.dx2            = W'(10);
    bus.data_valid     = 1'b1;
    bus.tr_mode_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sm", {31'd0, bus.drv_SM}, 32'd0);
    chk("rst_step", {31'd0, bus.drv_step}, 32'd0);
    chk("rst_dir", {31'd0, bus.drv_dir}, 32'd0);
    bus.data_valid     = 1'b0;
    bus.tr_mode_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_sample(25);
    repeat (3) @(negedge clk);
    chk("disabled_sm", {31'd0, bus.drv_SM}, 32'd0);
    wait_rise(20, n);
    chk("disabled_nostep", n, -32'sd1);

    // 2..4: classification and step rates
    bus.tr_mode_enable = 1'b1;
    run_case("fast_e20", 25, 1'b1, 1'b1, P_FAST);
    run_case("slow_e7",  12, 1'b1, 1'b1, P_SLOW);
    run_case("fast_e11", 16, 1'b1, 1'b1, P_FAST);
    run_case("slow_e10", 15, 1'b1, 1'b1, P_SLOW);
    run_case("idle_e5",  10, 1'b0, 1'b0, 0);
    run_case("idle_e3",   8, 1'b0, 1'b0, 0);
    run_case("slow_e6",  11, 1'b1, 1'b1, P_SLOW);

    // 5: negative error, then sign flip mid-period
    bus.x0 = W'(30);
    run_case("fast_neg", 10, 1'b1, 1'b0, P_FAST);
    repeat (300) @(negedge clk);
    do_sample(50);
    prev_dir  = bus.drv_dir;
    prev_step = bus.drv_step;
    n_dir     = -1;
    n_rise    = -1;
    for (int i = 1; i <= 1100; i++) begin
      if (n_rise < 0) begin
        @(negedge clk);
        if (bus.drv_dir !== prev_dir && n_dir < 0) n_dir = i;
        if (bus.drv_step === 1'b1 && prev_step === 1'b0) n_rise = i;
        prev_dir  = bus.drv_dir;
        prev_step = bus.drv_step;
      end
    end
    chk("flip_setup", n_rise - n_dir, 32'd1);
    chk("flip_dir", {31'd0, bus.drv_dir}, 32'd1);
    chk("flip_sm", {31'd0, bus.drv_SM}, 32'd1);
    chk("flip_period", 302 + n_rise, P_FAST);

    // 6: drop the permit while drv_step is high
    chk("pre_drop_step", {31'd0, bus.drv_step}, 32'd1);
    bus.tr_mode_enable = 1'b0;
    @(negedge clk);
    chk("drop_step", {31'd0, bus.drv_step}, 32'd0);
    chk("drop_sm", {31'd0, bus.drv_SM}, 32'd0);
    chk("drop_dir_hold", {31'd0, bus.drv_dir}, 32'd1);
    bus.x0 = W'(5);
    do_sample(25);
    repeat (3) @(negedge clk);
    chk("off_sample_sm", {31'd0, bus.drv_SM}, 32'd0);
    bus.tr_mode_enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("reenable_wait_sm", {31'd0, bus.drv_SM}, 32'd0);
    run_case("reenable_fast", 25, 1'b1, 1'b1, P_FAST);

    // dx2 below dx1: inside dead band parks, outside is fast
    bus.dx1 = W'(10);
    bus.dx2 = W'(3);
    run_case("inv_idle", 12, 1'b0, 1'b1, 0);
    run_case("inv_fast", 20, 1'b1, 1'b1, P_FAST);

    // reset mid-pulse drops outputs without waiting for a clock
    chk("pre_rst_step", {31'd0, bus.drv_step}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_step", {31'd0, bus.drv_step}, 32'd0);
    chk("async_rst_sm", {31'd0, bus.drv_SM}, 32'd0);
    chk("async_rst_dir", {31'd0, bus.drv_dir}, 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
